// File: rtl/logic_slice_seq_pkg.sv
// -----------------------------------------------------------------------------
// logic_slice_seq_pkg
// Shared definitions for the multi-cycle bitwise logic unit:
//   - op_e     : operation encodings (OP_AND, OP_OR, OP_XOR, OP_NOR)
//   - state_e  : sequencer state encodings (ST_IDLE, ST_RUN, ST_DONE)
//   - cnt_width: slice-counter width helper (clog2 of slice count, minimum 1)
// -----------------------------------------------------------------------------
package logic_slice_seq_pkg;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_NOR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // A single-slice configuration still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage : logic_slice_seq_pkg

// File: rtl/logic_slice.sv
// -----------------------------------------------------------------------------
// logic_slice
// Combinational SLICE-bit bitwise gate applying one of four operations.
// Ports:
//   a, b : input  [SLICE-1:0]  slice operands
//   op   : input  [1:0]        operation (op_e encoding)
//   y    : output [SLICE-1:0]  slice result
// -----------------------------------------------------------------------------
module logic_slice
   import logic_slice_seq_pkg::*;
#(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic [1:0]       op,
   output logic [SLICE-1:0] y
);

   // Operation decode for one slice.
   always_comb begin
      y = {SLICE{1'b0}};
      case (op_e'(op))
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOR:  y = ~(a | b);
         default: y = {SLICE{1'b0}};
      endcase
   end

endmodule : logic_slice

// File: rtl/logic_slice_seq.sv
// -----------------------------------------------------------------------------
// logic_slice_seq
// Multi-cycle WIDTH-bit bitwise logic unit. Operands are latched on the
// accepting edge and processed SLICE bits per clock, LSB slice first; the
// finished word is published to result/zero/parity in one step.
// Optional feature macro: LOGIC_SLICE_PARITY_EN (builds the running parity;
// otherwise parity is tied to 0).
// Ports:
//   clk    : input               rising-edge clock
//   rst_n  : input               synchronous active-low reset
//   start  : input               request, sampled only while ready=1
//   op     : input  [1:0]        00 AND, 01 OR, 10 XOR, 11 NOR
//   a, b   : input  [WIDTH-1:0]  operands
//   ready  : output              high only while idle
//   done   : output              one-cycle completion pulse
//   result : output [WIDTH-1:0]  last completed result
//   zero   : output              result == 0
//   parity : output              XOR-reduction of result
// -----------------------------------------------------------------------------
module logic_slice_seq
   import logic_slice_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             parity
);

   localparam int               N        = WIDTH / SLICE;
   localparam int               CNT_W    = cnt_width(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               done_q, done_d;
   logic               ready_q, ready_d;

   logic [SLICE-1:0]   a_sl_s;
   logic [SLICE-1:0]   b_sl_s;
   logic [SLICE-1:0]   y_sl_s;
   logic [WIDTH-1:0]   acc_ins_s;
   logic               accept_s;
   logic               last_slice_s;

   assign accept_s     = (state_q == ST_IDLE) && start;
   assign last_slice_s = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

   // Select the operand slice addressed by the counter.
   always_comb begin
      a_sl_s = {SLICE{1'b0}};
      b_sl_s = {SLICE{1'b0}};
      for (int i = 0; i < N; i++) begin
         a_sl_s = (cnt_q == CNT_W'(i)) ? a_q[i*SLICE +: SLICE] : a_sl_s;
         b_sl_s = (cnt_q == CNT_W'(i)) ? b_q[i*SLICE +: SLICE] : b_sl_s;
      end
   end

   logic_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .a  (a_sl_s),
      .b  (b_sl_s),
      .op (op_q),
      .y  (y_sl_s)
   );

   // Accumulator with the current slice result merged in; on the last slice
   // this is the complete word, so result is taken from here directly.
   always_comb begin
      acc_ins_s = acc_q;
      for (int i = 0; i < N; i++) begin
         acc_ins_s[i*SLICE +: SLICE] = (cnt_q == CNT_W'(i)) ? y_sl_s
                                                             : acc_ins_s[i*SLICE +: SLICE];
      end
   end

   // Next-state logic of the sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Working registers: operands latch only on acceptance, so later input
   // changes and busy-time start pulses cannot disturb them.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      op_d  = op_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      if (accept_s) begin
         a_d   = a;
         b_d   = b;
         op_d  = op;
         cnt_d = {CNT_W{1'b0}};
         acc_d = {WIDTH{1'b0}};
      end else if (state_q == ST_RUN) begin
         acc_d = acc_ins_s;
         // The counter parks at zero after the last slice instead of wrapping.
         if (last_slice_s) begin
            cnt_d = {CNT_W{1'b0}};
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Output logic: all outputs are computed from next state and registered.
   always_comb begin
      done_d  = last_slice_s;
      ready_d = (state_d == ST_IDLE);
      if (last_slice_s) begin
         result_d = acc_ins_s;
         zero_d   = (acc_ins_s == {WIDTH{1'b0}});
      end else begin
         result_d = result_q;
         zero_d   = zero_q;
      end
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         a_q      <= {WIDTH{1'b0}};
         b_q      <= {WIDTH{1'b0}};
         op_q     <= 2'b00;
         acc_q    <= {WIDTH{1'b0}};
         result_q <= {WIDTH{1'b0}};
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
      end
   end

`ifdef LOGIC_SLICE_PARITY_EN
   logic par_run_q, par_run_d;
   logic parity_q, parity_d;

   // Running parity folds in each slice result; the final fold is published
   // together with result.
   always_comb begin
      par_run_d = par_run_q;
      parity_d  = parity_q;
      if (accept_s) begin
         par_run_d = 1'b0;
      end else if (state_q == ST_RUN) begin
         par_run_d = par_run_q ^ (^y_sl_s);
         if (last_slice_s) begin
            parity_d = par_run_q ^ (^y_sl_s);
         end else begin
            parity_d = parity_q;
         end
      end else begin
         par_run_d = par_run_q;
      end
   end

   // Parity registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_run_q <= 1'b0;
         parity_q  <= 1'b0;
      end else begin
         par_run_q <= par_run_d;
         parity_q  <= parity_d;
      end
   end

   assign parity = parity_q;
`else
   assign parity = 1'b0;
`endif

   assign ready  = ready_q;
   assign done   = done_q;
   assign result = result_q;
   assign zero   = zero_q;

endmodule : logic_slice_seq

// File: tb/tb_logic_slice_seq.sv
// -----------------------------------------------------------------------------
// tb_logic_slice_seq
// Self-checking bench: a 16/4 instance checked every cycle against a
// timestamp-based transaction model, plus an 8/8 instance for the
// single-slice case. Parity expectation follows LOGIC_SLICE_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_logic_slice_seq;

   localparam int W  = 16;
   localparam int S  = 4;
   localparam int N  = W / S;
   localparam int W8 = 8;

`ifdef LOGIC_SLICE_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  a, b;
   logic          ready, done, zero, parity;
   logic [W-1:0]  result;

   logic          start8;
   logic [1:0]    op8;
   logic [W8-1:0] a8, b8;
   logic          ready8, done8, zero8, parity8;
   logic [W8-1:0] result8;

   always #5 clk = ~clk;

   logic_slice_seq #(.WIDTH(W), .SLICE(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .ready(ready), .done(done), .result(result), .zero(zero), .parity(parity)
   );

   logic_slice_seq #(.WIDTH(W8), .SLICE(W8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
      .ready(ready8), .done(done8), .result(result8), .zero(zero8), .parity(parity8)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
      case (o)
         2'd0:    return x & y;
         2'd1:    return x | y;
         2'd2:    return x ^ y;
         default: return ~(x | y);
      endcase
   endfunction

   // Transaction model: accepting edge e0 -> done after edge e0+N,
   // busy until edge e0+N+1.
   int           edge_n     = 0;
   int           done_edge  = -1;
   int           ready_back = 0;
   logic [W-1:0] m_pend     = '0;
   logic [W-1:0] m_res      = '0;
   bit           m_ready    = 1'b1;
   int           done_seen  = 0;
   int           last_done  = -1;
   int           done_gap   = 0;

   task automatic step();
      logic rst_at_edge;
      @(posedge clk);
      rst_at_edge = rst_n;
      edge_n++;
      if (!rst_at_edge) begin
         m_res      = '0;
         done_edge  = -1;
         ready_back = 0;
         m_ready    = 1'b1;
      end else begin
         if (m_ready && start) begin
            done_edge  = edge_n + N;
            ready_back = edge_n + N + 1;
            m_pend     = ref_op(op, a, b);
         end
         if (edge_n == done_edge) m_res = m_pend;
         m_ready = (edge_n >= ready_back);
      end
      #1;
      check_eq("done",   32'(done),   32'(edge_n == done_edge));
      check_eq("ready",  32'(ready),  32'(m_ready));
      check_eq("result", 32'(result), 32'(m_res));
      check_eq("zero",   32'(zero),   32'(m_res == '0));
      check_eq("parity", 32'(parity), 32'(PAR_EN ? ^m_res : 1'b0));
      if (done) begin
         done_seen++;
         done_gap  = edge_n - last_done;
         last_done = edge_n;
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      op = o; a = x; b = y; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
      step(); step();
      check_eq("rst_ready8",  32'(ready8),  32'd1);
      check_eq("rst_done8",   32'(done8),   32'd0);
      check_eq("rst_result8", 32'(result8), 32'd0);
      check_eq("rst_zero8",   32'(zero8),   32'd1);
      rst_n = 1'b1;
      step();

      // Basic AND: done exactly N cycles after acceptance.
      issue(2'b00, 16'hF0F0, 16'hFF00);
      for (int i = 0; i < N - 1; i++) step();
      check_eq("and_not_yet", 32'(done), 32'd0);
      step();
      check_eq("and_done",   32'(done),   32'd1);
      check_eq("and_result", 32'(result), 32'h0000_F000);
      check_eq("and_zero",   32'(zero),   32'd0);
      step(); step();

      // NOR to zero: ready low for N+1 samples after acceptance.
      issue(2'b11, 16'hFFFF, 16'h0000);
      check_eq("nor_busy0", 32'(ready), 32'd0);
      for (int i = 0; i < N; i++) begin
         step();
         check_eq("nor_busy", 32'(ready), 32'd0);
      end
      step();
      check_eq("nor_ready",  32'(ready),  32'd1);
      check_eq("nor_result", 32'(result), 32'd0);
      check_eq("nor_zero",   32'(zero),   32'd1);

      // Busy start ignored.
      issue(2'b01, 16'h00FF, 16'h0F0F);
      step(); step();
      done_seen = 0;
      issue(2'b00, 16'h0000, 16'h0000);
      for (int i = 0; i < 10; i++) step();
      check_eq("busy_dones",  32'(done_seen), 32'd1);
      check_eq("busy_result", 32'(result),    32'h0000_0FFF);

      // Mid-operation reset aborts without done.
      issue(2'b10, 16'h1234, 16'h4321);
      step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_eq("mrst_ready",  32'(ready),  32'd1);
      check_eq("mrst_result", 32'(result), 32'd0);
      check_eq("mrst_zero",   32'(zero),   32'd1);
      done_seen = 0;
      for (int i = 0; i < 10; i++) step();
      check_eq("mrst_dones", 32'(done_seen), 32'd0);

      // Back-to-back with start held: one done every N+2 cycles.
      op = 2'b10; a = 16'hAAAA; b = 16'h5555; start = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 3 * (N + 2) + 1; i++) begin
         step();
         if (done && done_seen > 1) check_eq("b2b_gap", 32'(done_gap), 32'(N + 2));
         if (done) begin
            check_eq("b2b_result", 32'(result), 32'h0000_FFFF);
            step();
            check_eq("b2b_width", 32'(done), 32'd0);
            i++;
         end
      end
      start = 1'b0;
      check_eq("b2b_count", 32'(done_seen), 32'd3);
      for (int i = 0; i < N + 2; i++) step();

      // Parity case on both configurations.
      op8 = 2'b10; a8 = 8'h07; b8 = 8'h00; start8 = 1'b1;
      issue(2'b10, 16'h0007, 16'h0000);
      start8 = 1'b0;
      check_eq("p8_ready", 32'(ready8), 32'd0);
      step();
      check_eq("p8_done",   32'(done8),   32'd1);
      check_eq("p8_result", 32'(result8), 32'h07);
      check_eq("p8_parity", 32'(parity8), 32'(PAR_EN));
      step();
      check_eq("p8_done_off", 32'(done8),  32'd0);
      check_eq("p8_ready_bk", 32'(ready8), 32'd1);
      for (int i = 0; i < N - 2; i++) step();
      check_eq("p_result", 32'(result), 32'h0000_0007);
      check_eq("p_parity", 32'(parity), 32'(PAR_EN));
      step();

      // Randomized traffic with occasional reset, checked every cycle.
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 2) == 0);
         op    = 2'($urandom_range(0, 3));
         a     = 16'($urandom);
         b     = 16'($urandom);
         rst_n = ($urandom_range(0, 63) != 0);
         step();
      end
      rst_n = 1'b1; start = 1'b0;
      for (int i = 0; i < N + 2; i++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_logic_slice_seq
